// File: rtl/mem_access_unit.sv
//==============================================================================
// Module      : mem_access_unit
// Description : Initiator for the data_memory port. Sequences single load/store
//               requests onto wr/rd/add/data_in and returns load data.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module mem_access_unit #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              busy,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_add,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [2:0] c_LAT = 3'(READ_LATENCY);

    logic [1:0]        r_state;
    logic [2:0]        r_cnt;
    logic              r_mem_wr;
    logic              r_mem_rd;
    logic [ADDR_W-1:0] r_mem_add;
    logic [DATA_W-1:0] r_mem_data_in;
    logic              r_resp_valid;
    logic [DATA_W-1:0] r_resp_rdata;
    logic              w_req_hs;

    // Gated by rst_n so the core never sees ready while reset is asserted.
    assign req_ready = rst_n & (r_state == S_IDLE);
    assign w_req_hs  = req_valid & req_ready;

    // The memory-side registers double as the request latch, so req_* changes
    // after the handshake cannot reach the memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= 3'd0;
            r_mem_wr      <= 1'b0;
            r_mem_rd      <= 1'b0;
            r_mem_add     <= '0;
            r_mem_data_in <= '0;
            r_resp_valid  <= 1'b0;
            r_resp_rdata  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req_hs) begin
                        r_state   <= S_ISSUE;
                        r_mem_add <= req_addr;
                        r_mem_wr  <= req_we;
                        r_mem_rd  <= ~req_we;
                        if (req_we) begin
                            r_mem_data_in <= req_wdata;
                        end
                    end
                end
                S_ISSUE: begin
                    r_mem_wr <= 1'b0;
                    r_mem_rd <= 1'b0;
                    if (r_mem_wr) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_WAIT;
                        r_cnt   <= c_LAT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 3'd1) begin
                        r_resp_rdata <= mem_data_out;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign mem_wr      = r_mem_wr;
    assign mem_rd      = r_mem_rd;
    assign mem_add     = r_mem_add;
    assign mem_data_in = r_mem_data_in;
    assign resp_valid  = r_resp_valid;
    assign resp_rdata  = r_resp_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
//==============================================================================
// Module      : tb_mem_access_unit
// Description : Bench for mem_access_unit; two builds (READ_LATENCY 1 and 3),
//               each paired with its own data_memory model.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_access_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic       req_valid1, req_we1, resp_ready1;
    logic [7:0] req_addr1, req_wdata1;
    logic       req_ready1, resp_valid1, busy1, mem_wr1, mem_rd1;
    logic [7:0] resp_rdata1, mem_add1, mem_data_in1, mem_data_out1;

    logic       req_valid3, req_we3, resp_ready3;
    logic [7:0] req_addr3, req_wdata3;
    logic       req_ready3, resp_valid3, busy3, mem_wr3, mem_rd3;
    logic [7:0] resp_rdata3, mem_add3, mem_data_in3, mem_data_out3;

    mem_access_unit #(.ADDR_W(8), .DATA_W(8), .READ_LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we1),
        .req_addr(req_addr1), .req_wdata(req_wdata1),
        .resp_valid(resp_valid1), .resp_ready(resp_ready1), .resp_rdata(resp_rdata1),
        .busy(busy1), .mem_wr(mem_wr1), .mem_rd(mem_rd1), .mem_add(mem_add1),
        .mem_data_in(mem_data_in1), .mem_data_out(mem_data_out1)
    );

    mem_access_unit #(.ADDR_W(8), .DATA_W(8), .READ_LATENCY(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid3), .req_ready(req_ready3), .req_we(req_we3),
        .req_addr(req_addr3), .req_wdata(req_wdata3),
        .resp_valid(resp_valid3), .resp_ready(resp_ready3), .resp_rdata(resp_rdata3),
        .busy(busy3), .mem_wr(mem_wr3), .mem_rd(mem_rd3), .mem_add(mem_add3),
        .mem_data_in(mem_data_in3), .mem_data_out(mem_data_out3)
    );

    // data_memory models: data_out becomes valid READ_LATENCY edges after the
    // sampling edge and is zero otherwise, so mistimed captures are visible.
    logic [7:0] mem1 [256];
    logic [7:0] mem3 [256];
    logic [7:0] pipe1;
    logic [7:0] pipe3 [3];
    always @(posedge clk) begin
        if (mem_wr1) mem1[mem_add1] <= mem_data_in1;
        pipe1 <= mem_rd1 ? mem1[mem_add1] : 8'h00;
        if (mem_wr3) mem3[mem_add3] <= mem_data_in3;
        pipe3[0] <= mem_rd3 ? mem3[mem_add3] : 8'h00;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign mem_data_out1 = pipe1;
    assign mem_data_out3 = pipe3[2];

    int n_cmp  = 0;
    int n_fail = 0;
    int rd_cnt1 = 0;
    logic [7:0]  ref_mem [2][256];
    logic [15:0] wq1 [$];
    logic [15:0] wq3 [$];
    logic [7:0]  rq1 [$];
    logic [7:0]  rq3 [$];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitors: write strobes and load responses against queued expectations.
    always @(negedge clk) begin
        if (rst_n) begin
            check("wr_rd_excl1", {15'd0, mem_wr1 & mem_rd1}, 16'd0);
            check("wr_rd_excl3", {15'd0, mem_wr3 & mem_rd3}, 16'd0);
            if (mem_rd1) rd_cnt1++;
            if (mem_wr1) begin
                if (wq1.size() == 0) check("wr_unexpected1", 16'd1, 16'd0);
                else check("wr_addr_data1", {mem_add1, mem_data_in1}, wq1.pop_front());
            end
            if (mem_wr3) begin
                if (wq3.size() == 0) check("wr_unexpected3", 16'd1, 16'd0);
                else check("wr_addr_data3", {mem_add3, mem_data_in3}, wq3.pop_front());
            end
            if (resp_valid1) begin
                if (rq1.size() == 0) check("resp_stale1", 16'd1, 16'd0);
                else if (resp_ready1) check("resp_data1", {8'd0, resp_rdata1}, {8'd0, rq1.pop_front()});
            end
            if (resp_valid3) begin
                if (rq3.size() == 0) check("resp_stale3", 16'd1, 16'd0);
                else if (resp_ready3) check("resp_data3", {8'd0, resp_rdata3}, {8'd0, rq3.pop_front()});
            end
        end
    end

    task automatic do_req(input bit s, input logic we, input logic [7:0] a, input logic [7:0] d);
        int n = 0;
        if (!s) begin
            req_valid1 = 1'b1; req_we1 = we; req_addr1 = a; req_wdata1 = d;
        end else begin
            req_valid3 = 1'b1; req_we3 = we; req_addr3 = a; req_wdata3 = d;
        end
        while (!(s ? req_ready3 : req_ready1) && n < 50) begin
            tick();
            n++;
        end
        check("req_accept_timeout", {15'd0, n < 50}, 16'd1);
        tick();
        if (!s) req_valid1 = 1'b0;
        else    req_valid3 = 1'b0;
        if (we) begin
            ref_mem[s][a] = d;
            if (!s) wq1.push_back({a, d});
            else    wq3.push_back({a, d});
        end else begin
            if (!s) rq1.push_back(ref_mem[s][a]);
            else    rq3.push_back(ref_mem[s][a]);
        end
    endtask

    task automatic wait_idle(input bit s);
        int n = 0;
        while (((s ? busy3 : busy1) || ((s ? rq3.size() : rq1.size()) != 0)) && n < 100) begin
            tick();
            n++;
        end
        check("idle_timeout", {15'd0, n < 100}, 16'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc;
        int n;
        rst_n = 1'b0;
        req_valid1 = 0; req_we1 = 0; req_addr1 = 0; req_wdata1 = 0; resp_ready1 = 1;
        req_valid3 = 0; req_we3 = 0; req_addr3 = 0; req_wdata3 = 0; resp_ready3 = 1;
        tick();
        check("rst_req_ready",  {15'd0, req_ready1},  16'd0);
        check("rst_resp_valid", {15'd0, resp_valid1}, 16'd0);
        check("rst_strobes",    {14'd0, mem_wr1, mem_rd1}, 16'd0);
        check("rst_busy",       {15'd0, busy1}, 16'd0);
        check("rst_add_din",    {mem_add1, mem_data_in1}, 16'd0);
        check("rst_rdata",      {8'd0, resp_rdata1}, 16'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", {14'd0, req_ready1, req_ready3}, 16'd3);

        // Store then load at 0x05
        do_req(0, 1'b1, 8'h05, 8'hAA);
        check("st_issue", {13'd0, mem_wr1, mem_rd1, busy1}, 16'b101);
        check("st_add_din", {mem_add1, mem_data_in1}, 16'h05AA);
        tick();
        check("st_done", {13'd0, mem_wr1, req_ready1, busy1}, 16'b010);
        do_req(0, 1'b0, 8'h05, 8'h00);
        check("ld_issue", {7'd0, mem_rd1, mem_add1}, 16'h0105);
        check("ld_e0_valid", {15'd0, resp_valid1}, 16'd0);
        tick();
        check("ld_e1", {14'd0, resp_valid1, mem_rd1}, 16'd0);
        tick();
        check("ld_e2_valid", {15'd0, resp_valid1}, 16'd1);
        check("ld_e2_data", {8'd0, resp_rdata1}, 16'h00AA);
        tick();
        check("ld_released", {14'd0, resp_valid1, busy1}, 16'd0);

        // Back-to-back stores at the address extremes, then loads
        do_req(0, 1'b1, 8'h00, 8'h11);
        check("b2b_ready_low1", {15'd0, req_ready1}, 16'd0);
        tick();
        check("b2b_ready_high1", {15'd0, req_ready1}, 16'd1);
        do_req(0, 1'b1, 8'hFF, 8'h22);
        check("b2b_ready_low2", {15'd0, req_ready1}, 16'd0);
        tick();
        check("b2b_ready_high2", {15'd0, req_ready1}, 16'd1);
        do_req(0, 1'b0, 8'h00, 8'h00);
        wait_idle(0);
        do_req(0, 1'b0, 8'hFF, 8'h00);
        wait_idle(0);

        // Response back-pressure; a request presented during RESP must be ignored
        resp_ready1 = 1'b0;
        do_req(0, 1'b0, 8'hFF, 8'h00);
        n = 0;
        while (!resp_valid1 && n < 20) begin tick(); n++; end
        check("bp_valid_timeout", {15'd0, n < 20}, 16'd1);
        rc = rd_cnt1;
        req_valid1 = 1'b1; req_we1 = 1'b1; req_addr1 = 8'h10; req_wdata1 = 8'h99;
        for (int k = 0; k < 5; k++) begin
            check("bp_hold", {5'd0, resp_valid1, req_ready1, mem_wr1, resp_rdata1}, 16'h0422);
            tick();
        end
        check("bp_no_rd", 16'(rd_cnt1), 16'(rc));
        req_valid1 = 1'b0;
        resp_ready1 = 1'b1;
        tick();
        check("bp_taken", {15'd0, resp_valid1}, 16'd0);
        wait_idle(0);

        // READ_LATENCY=3 build
        do_req(1, 1'b1, 8'h33, 8'h5C);
        wait_idle(1);
        do_req(1, 1'b0, 8'h33, 8'h00);
        for (int k = 0; k < 4; k++) begin
            check("lat3_early", {15'd0, resp_valid3}, 16'd0);
            tick();
        end
        check("lat3_valid", {15'd0, resp_valid3}, 16'd1);
        check("lat3_data", {8'd0, resp_rdata3}, 16'h005C);
        wait_idle(1);

        // Reset during WAIT discards the pending load
        do_req(0, 1'b0, 8'h05, 8'h00);
        tick();
        check("rst_mid_busy", {15'd0, busy1}, 16'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_outs", {12'd0, resp_valid1, mem_rd1, busy1, req_ready1}, 16'd0);
        rq1.delete();
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("rst_after", {14'd0, resp_valid1, req_ready1}, 16'b01);
        end

        // Request inputs changing after the handshake must not reach the memory
        do_req(0, 1'b1, 8'h40, 8'h77);
        req_addr1 = 8'h99; req_wdata1 = 8'h00;
        #1;
        check("latch_st", {mem_add1, mem_data_in1}, 16'h4077);
        wait_idle(0);
        do_req(0, 1'b0, 8'h40, 8'h00);
        req_addr1 = 8'h05;
        #1;
        check("latch_ld", {8'd0, mem_add1}, 16'h0040);
        wait_idle(0);

        check("wq_drained", 16'(wq1.size() + wq3.size()), 16'd0);
        check("rq_drained", 16'(rq1.size() + rq3.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
